// File: rtl/ps2_key_queue_if.sv
// Pop-side handshake between the key queue and the display FSM.
// The queue drives the head entry and occupancy; the consumer drives Key_ack.
interface ps2_key_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [8:0]    Key_code;
  logic          Key_valid;
  logic          Key_ack;
  logic [CW-1:0] Key_count;

  modport master (
    output Key_code,
    output Key_valid,
    output Key_count,
    input  Key_ack
  );

  modport slave (
    input  Key_code,
    input  Key_valid,
    input  Key_count,
    output Key_ack
  );
endinterface

// File: rtl/ps2_key_queue.sv
// Conditions the PS2 controller code stream (modifiers, breaks, repeats) and
// buffers tagged make codes in a first-word fall-through FIFO.
module ps2_key_queue #(
  parameter int DEPTH           = 8,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       Clock_50,
  input  logic       Resetn,
  input  logic [8:0] PS2_code,
  input  logic       PS2_code_ready,
  input  logic       PS2_make_code,
  ps2_key_queue_if.master key,
  output logic       Overflow,
  input  logic       Clear_overflow,
  output logic       Shift_active,
  output logic       Caps_lock
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Event detection
  logic ready_buf_reg;
  logic armed_reg;
  logic code_event;

  // Modifier / repeat tracking
  logic       lshift_held_reg, lshift_held_next;
  logic       rshift_held_reg, rshift_held_next;
  logic       caps_held_reg,   caps_held_next;
  logic       caps_lock_reg,   caps_lock_next;
  logic       shift_active_reg;
  logic [7:0] last_make_reg,   last_make_next;
  logic       last_valid_reg,  last_valid_next;

  // FIFO
  logic [8:0]    mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;

  logic [7:0] scan;
  logic       is_lshift, is_rshift, is_caps, is_mod;
  logic       key_event, repeat_hit;
  logic       push_req, break_clear;
  logic [8:0] push_data;
  logic       full, pop, push_ok, drop;

  assign scan      = PS2_code[7:0];
  assign is_lshift = (scan == SC_LSHIFT);
  assign is_rshift = (scan == SC_RSHIFT);
  assign is_caps   = (scan == SC_CAPS);
  assign is_mod    = is_lshift | is_rshift | is_caps;

  // armed_reg blocks a level that was already high when reset released
  // from looking like a fresh rising edge.
  assign code_event  = PS2_code_ready & ~ready_buf_reg & armed_reg;
  assign key_event   = code_event & ~is_mod & ~PS2_code[8];
  assign repeat_hit  = last_valid_reg & (scan == last_make_reg);
  assign push_req    = key_event & PS2_make_code & ~(SUPPRESS_REPEAT & repeat_hit);
  assign break_clear = key_event & ~PS2_make_code & repeat_hit;
  assign push_data   = {shift_active_reg ^ caps_lock_reg, scan};

  assign full    = (count_reg == CW'(DEPTH));
  assign pop     = (count_reg != '0) & key.Key_ack;
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      ready_buf_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      ready_buf_reg <= PS2_code_ready;
      armed_reg     <= armed_reg | ~PS2_code_ready;
    end
  end

  always_comb begin
    lshift_held_next = lshift_held_reg;
    rshift_held_next = rshift_held_reg;
    caps_held_next   = caps_held_reg;
    caps_lock_next   = caps_lock_reg;
    last_make_next   = last_make_reg;
    last_valid_next  = last_valid_reg;
    if (code_event) begin
      if (is_lshift) lshift_held_next = PS2_make_code;
      if (is_rshift) rshift_held_next = PS2_make_code;
      if (is_caps) begin
        if (PS2_make_code) begin
          if (!caps_held_reg) begin
            caps_lock_next = ~caps_lock_reg;
            caps_held_next = 1'b1;
          end
        end else begin
          caps_held_next = 1'b0;
        end
      end
    end
    // last_make follows every accepted make, even one later dropped by a full queue
    if (push_req) begin
      last_make_next  = scan;
      last_valid_next = 1'b1;
    end else if (break_clear) begin
      last_valid_next = 1'b0;
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      lshift_held_reg  <= 1'b0;
      rshift_held_reg  <= 1'b0;
      caps_held_reg    <= 1'b0;
      caps_lock_reg    <= 1'b0;
      shift_active_reg <= 1'b0;
      last_make_reg    <= 8'h00;
      last_valid_reg   <= 1'b0;
    end else begin
      lshift_held_reg  <= lshift_held_next;
      rshift_held_reg  <= rshift_held_next;
      caps_held_reg    <= caps_held_next;
      caps_lock_reg    <= caps_lock_next;
      shift_active_reg <= lshift_held_next | rshift_held_next;
      last_make_reg    <= last_make_next;
      last_valid_reg   <= last_valid_next;
    end
  end

  // Storage is reset so Key_code reads zero out of reset.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= 9'h000;
      end
    end else if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
      if (drop)
        overflow_reg <= 1'b1;
      else if (Clear_overflow)
        overflow_reg <= 1'b0;
    end
  end

  assign key.Key_code  = mem_reg[rd_ptr_reg];
  assign key.Key_valid = (count_reg != '0);
  assign key.Key_count = count_reg;
  assign Overflow      = overflow_reg;
  assign Shift_active  = shift_active_reg;
  assign Caps_lock     = caps_lock_reg;

endmodule

// File: doc/ps2_key_queue.md
# ps2_key_queue

Keystroke conditioning and buffering stage between `PS2_controller` and the display FSM.
- Watches the PS2 controller's code stream and tracks modifier state (shift, caps lock).
- Drops break codes, modifiers and typematic repeats.
- Tags each surviving make code with an upper-case flag and queues it in a small FIFO.
- The display FSM pops keys with a valid/ack handshake, so keystrokes arriving during long LCD writes are not lost.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- SUPPRESS_REPEAT, 1, 1 = discard typematic repeat makes; 0 = queue them.

Ports:
- Clock_50  in  1  system clock, 50 MHz.
- Resetn  in  1  reset, asynchronous, active-low.
- PS2_code  in  9  code from `PS2_controller`; bit 8 = extended flag, [7:0] = scan code.
- PS2_code_ready  in  1  level from controller; a rising edge marks a new code.
- PS2_make_code  in  1  1 = make, 0 = break; valid with the code.
- Key_code  out  9  queue head; bit 8 = upper-case flag, [7:0] = scan code.
- Key_valid  out  1  queue non-empty; Key_code is valid.
- Key_ack  in  1  pop request; honoured only when Key_valid=1.
- Key_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- Overflow  out  1  sticky; a key was dropped because the queue was full.
- Clear_overflow  in  1  synchronous clear of Overflow.
- Shift_active  out  1  left or right shift currently held.
- Caps_lock  out  1  caps lock toggle state.

## Operation
- Event detection:
  - Register PS2_code_ready into ready_buf.
  - An event occurs in any cycle with PS2_code_ready=1 and ready_buf=0.
  - PS2_code and PS2_make_code are sampled in that same cycle.
- Modifiers (matched on [7:0] only, bit 8 ignored):
  - 0x12 sets/clears lshift_held on make/break.
  - 0x59 sets/clears rshift_held on make/break.
  - 0x58 make with caps_held=0 toggles Caps_lock and sets caps_held; 0x58 break clears caps_held.
  - Modifier events are never queued.
- Non-modifier events:
  - Extended codes (bit 8 = 1): discarded.
  - Break: discarded. If the break's code equals last_make and last_valid=1, clear last_valid.
  - Make:
    - If SUPPRESS_REPEAT=1, last_valid=1 and the code equals last_make, discard it.
    - Otherwise push {Shift_active ^ Caps_lock, code[7:0]}, load last_make ← code and set last_valid.
    - Shift/caps values used for the flag are those registered before the event.
- FIFO:
  - Circular buffer with write pointer, read pointer and count.
  - Pointers wrap modulo DEPTH.
  - Key_code always shows the entry at the read pointer (first-word fall-through).
- Push and pop rules:
  - Pop when Key_valid & Key_ack.
  - Push while not full: accepted.
  - Push while full with a pop in the same cycle: accepted; count stays DEPTH.
  - Push while full with no pop: key dropped, Overflow ← 1, pointers unchanged.
  - Simultaneous push and pop at count=1: entry replaced; Key_valid stays 1.
- Overflow:
  - Clear_overflow clears it.
  - If a drop coincides with Clear_overflow, the set wins.
- Outputs:
  - Shift_active = lshift_held | rshift_held (registered).
  - Key_valid = (count != 0).

## Timing
- Reset (asynchronous) values:
  - Outputs: Key_valid 0, Key_code 0, Key_count 0, Overflow 0, Shift_active 0, Caps_lock 0.
  - Internal: ready_buf 0, held flags 0, last_valid 0, pointers 0.
- Latency:
  - Rising edge of PS2_code_ready in cycle N → Key_valid=1 and Key_code updated in cycle N+1 (queue previously empty).
  - Pop at edge ending cycle M → next entry (or Key_valid=0) in cycle M+1.
  - Modifier event in cycle N → Shift_active/Caps_lock change in cycle N+1.
  - A key event in cycle N+1 sees the new modifier state.
- Handshake:
  - Key_ack while Key_valid=0 has no effect; no pointer movement and no underflow.
  - Key_ack held high drains one entry per cycle.
- PS2_code_ready held high for many cycles produces exactly one event.
- Reset asserted mid-operation empties the queue and clears all state immediately. The first event after release requires a fresh rising edge of PS2_code_ready.

## Test plan
- Rising edge with code 0x01C, make=1 → next cycle Key_valid=1, Key_code=0x01C, Key_count=1; Key_ack pulse → Key_valid=0, count 0.
- Make 0x012, make 0x01C, break 0x012, make 0x032 → queue holds 0x11C then 0x032; Shift_active 1 then 0; no 0x012 entry.
- Make 0x058, break 0x058, make 0x01C → Caps_lock=1, entry 0x11C. Then make 0x012 and make 0x023 → entry 0x023 (shift XOR caps = 0).
- SUPPRESS_REPEAT=1: make 0x01C ×3, break 0x01C, make 0x01C → exactly 2 entries of 0x01C.
- DEPTH=8: push 9 distinct makes without Key_ack → count 8, Overflow=1, head is the first key. Clear_overflow → 0. Ack plus push in the same cycle at full → count stays 8, order preserved.
- Push 3 keys, assert Resetn=0 mid-stream → all outputs 0 asynchronously. After release, PS2_code_ready already high → no event until it falls and rises again.
